// File: rtl/comp_arb_pkg.sv
// comp_arb_pkg: FSM states and compare-op encodings shared by the comparator arbiter
package comp_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;
  localparam logic [2:0] CMP_GE = 3'b000;
  localparam logic [2:0] CMP_NE = 3'b001;
  localparam logic [2:0] CMP_GT = 3'b101;
  localparam logic [2:0] CMP_LT = 3'b100;
endpackage

// File: rtl/zero_extend_comp.sv
// zero_extend_comp: 32-bit comparator, outcome zero-extended into result_o
//   a_i/b_i operands, funct3_i op select, funct7_i zero = signed else unsigned, result_o bit 0 = outcome
module zero_extend_comp
  import comp_arb_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output logic [31:0] result_o
);
  logic [31:0] diff;
  logic sgn, lt, eq;
  always_comb begin
    sgn = funct7_i == 7'd0;
    diff = a_i - b_i;
    eq = diff == 32'd0;
    // with equal top bits the wrapped difference sign decides; otherwise the top bits decide
    lt = (a_i[31] ^ b_i[31]) ? (sgn ? a_i[31] : b_i[31]) : diff[31];
    result_o = {31'd0, funct3_i == CMP_GE ? !lt :
                       funct3_i == CMP_NE ? !eq :
                       funct3_i == CMP_GT ? (!lt && !eq) :
                       funct3_i == CMP_LT ? lt : (lt || eq)};
  end
endmodule

// File: rtl/comp_share_arbiter.sv
// comp_share_arbiter: shares one comparator between branch (req0) and slt (req1) requesters
//   req_valid/req_ready per-requester handshake, reqN_a/b/funct3 operands,
//   rsp_valid/rsp_ready response handshake with rsp_id/rsp_result, flush aborts, busy = not IDLE
module comp_share_arbiter
  import comp_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_funct3,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_funct3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_result,
  output logic              busy
);
  state_e state_q, state_d;
  logic last_q, id_q, res_q, gnt;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0] f3_q;
  logic [31:0] cmp_res;
  zero_extend_comp u_cmp (
    .a_i      (a_q),
    .b_i      (b_q),
    .funct3_i (f3_q),
    .funct7_i (7'd0),
    .result_o (cmp_res)
  );
  always_comb begin
    // on contention round-robin hands the grant to whoever did not win last
    gnt = req_valid == 2'b10 || (req_valid == 2'b11 && !FIXED_PRIO && !last_q);
    req_ready = (state_q == IDLE && !flush && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    state_d = flush ? IDLE :
              state_q == IDLE ? (|req_ready ? EVAL : IDLE) :
              state_q == EVAL ? RESP :
              state_q == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
    rsp_valid = state_q == RESP;
    rsp_id = id_q;
    rsp_result = res_q;
    busy = state_q != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      res_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      f3_q <= '0;
    end else begin
      state_q <= state_d;
      if (|req_ready) begin
        a_q <= gnt ? req1_a : req0_a;
        b_q <= gnt ? req1_b : req0_b;
        f3_q <= gnt ? req1_funct3 : req0_funct3;
        id_q <= gnt;
        last_q <= gnt;
      end
      // result is zero-extended, so any set bit is the outcome bit
      if (state_q == EVAL) res_q <= |cmp_res;
    end
  end
endmodule
